tx_arbiter: RTL

- Shares the single transmit link among NREQ frame sources using round-robin arbitration.
- Drives the link enable (txen) and per-requester grants, and counts backpressure cycles within each frame.
- Aborts and quarantines any requester whose frame exceeds BPLIMIT backpressure cycles.
- Sits between the frame sources and the transmit serializer; it is the sequencer for the transmit fail-safe path.

---
 rtl/tx_arb_pkg.sv | 13 +
 rtl/tx_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 35 +++
 rtl/tx_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the transmit arbiter and the fail-safe path.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACTIVE = 2'd1,
    ARB_ABORT  = 2'd2
  } states_t;

  // Backpressure cycles tolerated within one frame before it is aborted.
  localparam int BPLIMIT_DEFAULT = 512;

endpackage

// File: rtl/tx_arbiter_if.sv
// Frame-source / link handshake bundle around the transmit arbiter.
interface tx_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] last;
  logic            bp_enb;
  logic [NREQ-1:0] fault_clr;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   sel;
  logic            txen;
  logic [NREQ-1:0] fault;
  logic            busy;

  // Arbiter side.
  modport master (
    input  req, last, bp_enb, fault_clr,
    output gnt, sel, txen, fault, busy
  );

  // Frame sources / serializer side.
  modport slave (
    output req, last, bp_enb, fault_clr,
    input  gnt, sel, txen, fault, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            win_vld
);

  // ptr is always a valid index, so one subtraction keeps ptr+k in range.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

  // Scan from ptr+1 around to ptr itself; the first hit wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_vld && elig[wrap_add(ptr, k)]) begin
        win_vld                  = 1'b1;
        win_idx                  = wrap_add(ptr, k);
        win_oh[wrap_add(ptr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin transmit-link arbiter with per-frame backpressure watchdog.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int BPLIMIT = BPLIMIT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  tx_arbiter_if.master bus
);

  localparam int CW = $clog2(BPLIMIT + 1);
  localparam int IW = $clog2(NREQ);
  localparam logic [CW-1:0] BP_MAX  = CW'(BPLIMIT);
  localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

  states_t         state_q, state_d;
  logic [CW-1:0]   bpcount_q, bpcount_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] fault_q, fault_d;
  logic            txen_q, txen_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_vld;

  // Stall counter stops at the limit so it can never wrap past the check.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= BP_MAX) ? BP_MAX : v + CW'(1);
  endfunction

  assign elig = bus.req & ~fault_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .elig    (elig),
    .ptr     (rr_ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Next-state and output decode; a fault set on the abort edge beats a clear.
  always_comb begin
    state_d   = state_q;
    bpcount_d = bpcount_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    txen_d    = txen_q;
    fault_d   = fault_q & ~bus.fault_clr;
    case (state_q)
      ARB_IDLE: begin
        bpcount_d = '0;
        gnt_d     = '0;
        txen_d    = 1'b0;
        if (win_vld) begin
          gnt_d    = win_oh;
          sel_d    = win_idx;
          txen_d   = 1'b1;
          rr_ptr_d = win_idx;
          state_d  = ARB_ACTIVE;
        end
      end
      ARB_ACTIVE: begin
        if (bpcount_q >= BP_MAX) begin
          fault_d   = fault_d | gnt_q;
          gnt_d     = '0;
          txen_d    = 1'b0;
          bpcount_d = '0;
          state_d   = ARB_ABORT;
        end else if (!bus.req[sel_q] || (!bus.bp_enb && bus.last[sel_q])) begin
          gnt_d     = '0;
          txen_d    = 1'b0;
          bpcount_d = '0;
          state_d   = ARB_IDLE;
        end else if (bus.bp_enb) begin
          bpcount_d = sat_inc(bpcount_q);
        end
      end
      ARB_ABORT: begin
        gnt_d     = '0;
        txen_d    = 1'b0;
        bpcount_d = '0;
        state_d   = ARB_IDLE;
      end
      default: begin
        gnt_d     = '0;
        txen_d    = 1'b0;
        bpcount_d = '0;
        state_d   = ARB_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset returns to priority on requester 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      bpcount_q <= '0;
      rr_ptr_q  <= PTR_RST;
      sel_q     <= '0;
      gnt_q     <= '0;
      txen_q    <= 1'b0;
      fault_q   <= '0;
    end else begin
      state_q   <= state_d;
      bpcount_q <= bpcount_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      txen_q    <= txen_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.txen  = txen_q;
  assign bus.fault = fault_q;
  assign bus.busy  = (state_q != ARB_IDLE);

endmodule
